// File: rtl/fim_scfifo_rr_sched.sv
// Round-robin read scheduler: drains NUM_FIFOS fim_scfifo banks into a single
// valid/ready stream. One read request per cycle at most, credit-limited by
// the local output buffer so a word already requested always has a slot.
module fim_scfifo_rr_sched #(
    parameter  int NUM_FIFOS  = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int OUT_DEPTH  = 4,
    localparam int SRC_W      = $clog2(NUM_FIFOS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_FIFOS-1:0]            src_enable,
    input  logic [NUM_FIFOS-1:0]            fifo_r_empty,
    input  logic [NUM_FIFOS-1:0]            fifo_r_valid,
    input  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_r_data,
    output logic [NUM_FIFOS-1:0]            fifo_r_req,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [SRC_W-1:0]                out_src,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            err_sticky
);

    localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W  = $clog2(OUT_DEPTH + 1);
    localparam int WORD_W = DATA_WIDTH + SRC_W;

    // Arbiter signals
    logic [NUM_FIFOS-1:0]  w_elig;
    logic [NUM_FIFOS-1:0]  w_req;
    logic                  w_credit;
    logic                  w_grant_found;
    logic                  w_issue;
    logic [SRC_W-1:0]      w_grant_idx;
    logic [SRC_W-1:0]      w_cand;
    logic [SRC_W-1:0]      r_last;
    logic                  r_inflight;
    logic [SRC_W-1:0]      r_inflight_src;

    // Return path and output buffer signals
    logic                  w_ret_valid;
    logic [DATA_WIDTH-1:0] w_ret_data;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_overflow;
    logic                  w_push_ok;
    logic                  w_missing;
    logic                  w_stray_valid;
    logic [WORD_W-1:0]     r_mem [OUT_DEPTH];
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      w_rd_ptr_nxt;
    logic [CNT_W-1:0]      r_count;
    logic                  w_head_load;
    logic [WORD_W-1:0]     w_head_word;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [SRC_W-1:0]      r_out_src;
    logic                  r_err;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_elig   = src_enable & ~fifo_r_empty;
    // Registered occupancy only: downstream ready never reaches the request.
    assign w_credit = (int'(r_count) + int'(r_inflight)) < OUT_DEPTH;
    assign w_issue  = w_credit & w_grant_found;

    // Rotating search for the first eligible source after the last grant.
    always_comb begin
        // NOTE: every always_comb output is given a default first so no latch is inferred.
        w_grant_found = 1'b0;
        w_grant_idx   = r_last;
        w_cand        = r_last;
        for (int k = 1; k <= NUM_FIFOS; k++) begin
            w_cand = SRC_W'((int'(r_last) + k) % NUM_FIFOS);
            if (!w_grant_found && w_elig[w_cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
    end

    // One-hot request, forced low while reset is asserted.
    always_comb begin
        w_req = '0;
        if (!rst && w_issue) begin
            w_req[w_grant_idx] = 1'b1;
        end
    end

    assign fifo_r_req = w_req;

    // Round-robin pointer and in-flight tracking.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (rst) begin
            r_last         <= SRC_W'(NUM_FIFOS - 1);
            r_inflight     <= 1'b0;
            r_inflight_src <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_last         <= w_grant_idx;
                r_inflight_src <= w_grant_idx;
            end
        end
    end

    // The word returns the cycle after the request, from the granted source.
    assign w_ret_valid   = fifo_r_valid[r_inflight_src];
    assign w_ret_data    = fifo_r_data[int'(r_inflight_src)*DATA_WIDTH +: DATA_WIDTH];
    assign w_push        = r_inflight & w_ret_valid;
    assign w_pop         = (r_count != '0) & out_ready;
    assign w_overflow    = w_push & (r_count == CNT_W'(OUT_DEPTH)) & ~w_pop;
    assign w_push_ok     = w_push & ~w_overflow;
    assign w_missing     = r_inflight & ~w_ret_valid;
    assign w_stray_valid = ~r_inflight & (|fifo_r_valid);
    assign w_rd_ptr_nxt  = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;

    // Next head word: the arriving word when the buffer drains to empty,
    // otherwise the following stored entry after a pop.
    always_comb begin
        w_head_load = 1'b0;
        w_head_word = {w_ret_data, r_inflight_src};
        if (w_push_ok && ((r_count - CNT_W'(w_pop)) == '0)) begin
            w_head_load = 1'b1;
        end else if (w_pop && (r_count > CNT_W'(1))) begin
            w_head_load = 1'b1;
            w_head_word = r_mem[w_rd_ptr_nxt];
        end
    end

    // Buffer storage array written at the tail.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; count and pointers decide which entries are live.
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {w_ret_data, r_inflight_src};
        end
    end

    // Buffer pointers, occupancy, registered head and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_out_data <= '0;
            r_out_src  <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
            if (w_head_load) begin
                {r_out_data, r_out_src} <= w_head_word;
            end
            if (w_missing || w_stray_valid || w_overflow) begin
                r_err <= 1'b1;
            end
        end
    end

    assign out_data   = r_out_data;
    assign out_src    = r_out_src;
    assign out_valid  = (r_count != '0);
    assign err_sticky = r_err;

endmodule

// File: tb/tb_fim_scfifo_rr_sched.sv
// Directed bench for fim_scfifo_rr_sched with a behavioural model of the
// source FIFOs (one-cycle read latency) and hand-derived expected streams.
module tb_fim_scfifo_rr_sched;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    src_enable;
    logic [N-1:0]    fifo_r_empty;
    logic [N-1:0]    fifo_r_valid;
    logic [N*DW-1:0] fifo_r_data;
    logic [N-1:0]    fifo_r_req;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_src;
    logic            out_valid;
    logic            out_ready;
    logic            err_sticky;

    fim_scfifo_rr_sched #(
        .NUM_FIFOS (N),
        .DATA_WIDTH(DW),
        .OUT_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_enable  (src_enable),
        .fifo_r_empty(fifo_r_empty),
        .fifo_r_valid(fifo_r_valid),
        .fifo_r_data (fifo_r_data),
        .fifo_r_req  (fifo_r_req),
        .out_data    (out_data),
        .out_src     (out_src),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_sticky  (err_sticky)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          rd_idx [N];
    int          wr_idx [N];
    logic        drop;
    logic [33:0] out_q [$];
    int          out_cyc [$];
    int          grant_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int s, input int k);
        return 32'hA000_0000 | (32'(s) << 16) | 32'(k);
    endfunction

    task automatic update_empty();
        for (int i = 0; i < N; i++) fifo_r_empty[i] = (rd_idx[i] == wr_idx[i]);
    endtask

    task automatic load(input int s, input int n);
        wr_idx[s] += n;
        update_empty();
    endtask

    task automatic clear_logs();
        out_q.delete();
        out_cyc.delete();
        grant_q.delete();
    endtask

    task automatic clear_model();
        fifo_r_valid = '0;
        drop = 1'b0;
        for (int i = 0; i < N; i++) begin
            rd_idx[i] = 0;
            wr_idx[i] = 0;
        end
        update_empty();
    endtask

    // One clock: sample requests/handshake before the edge, then model the
    // source FIFOs answering the request one cycle later.
    task automatic tick();
        logic [N-1:0] req;
        #1;
        req = fifo_r_req;
        if (out_valid && out_ready) begin
            out_q.push_back({out_src, out_data});
            out_cyc.push_back(cyc);
        end
        if (req != '0) begin
            check("req_onehot", 64'($countones(req)), 64'd1);
            for (int i = 0; i < N; i++) if (req[i]) grant_q.push_back(i);
        end
        @(posedge clk);
        #1;
        cyc++;
        fifo_r_valid = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                check($sformatf("req_nonempty_%0d", i), 64'(rd_idx[i] < wr_idx[i]), 64'd1);
                fifo_r_data[i*DW +: DW] = mk(i, rd_idx[i]);
                if (rd_idx[i] < wr_idx[i]) rd_idx[i]++;
                if (!drop) fifo_r_valid[i] = 1'b1;
            end
        end
        update_empty();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic check_out(input string tag, input int idx, input int s, input int k);
        if (idx < out_q.size())
            check($sformatf("%s_%0d", tag, idx), 64'(out_q[idx]), 64'({2'(s), mk(s, k)}));
        else
            check($sformatf("%s_%0d_missing", tag, idx), 64'(out_q.size()), 64'(idx + 1));
    endtask

    task automatic check_grant(input string tag, input int idx, input int s);
        if (idx < grant_q.size())
            check($sformatf("%s_%0d", tag, idx), 64'(grant_q[idx]), 64'(s));
        else
            check($sformatf("%s_%0d_missing", tag, idx), 64'(grant_q.size()), 64'(idx + 1));
    endtask

    initial begin
        rst         = 1'b1;
        src_enable  = '1;
        fifo_r_data = '0;
        out_ready   = 1'b1;
        clear_model();
        #1;
        check("rst_req",   64'(fifo_r_req), 64'd0);
        check("rst_valid", 64'(out_valid),  64'd0);
        check("rst_data",  64'(out_data),   64'd0);
        check("rst_src",   64'(out_src),    64'd0);
        check("rst_err",   64'(err_sticky), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Fairness: 4 x 8 words drain as 0,1,2,3 repeated, back to back.
        clear_logs();
        for (int s = 0; s < N; s++) load(s, 8);
        run(45);
        check("t2_count", 64'(out_q.size()), 64'd32);
        check("t2_grants", 64'(grant_q.size()), 64'd32);
        for (int i = 0; i < 32; i++) check_out("t2_word", i, i % 4, i / 4);
        if (out_cyc.size() == 32) check("t2_span", 64'(out_cyc[31] - out_cyc[0]), 64'd31);
        check("t2_err", 64'(err_sticky), 64'd0);

        // Reset mid-stream: outputs and request drop in the same cycle.
        do_reset();
        for (int s = 0; s < N; s++) load(s, 4);
        run(5);
        check("t1_busy", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("t1_req",   64'(fifo_r_req), 64'd0);
        check("t1_valid", 64'(out_valid),  64'd0);
        check("t1_data",  64'(out_data),   64'd0);
        check("t1_src",   64'(out_src),    64'd0);
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        run(3);
        check("t1_idle_valid", 64'(out_valid), 64'd0);
        check("t1_idle_grants", 64'(grant_q.size()), 64'd0);
        load(1, 1);
        tick();
        check_grant("t1_grant", 0, 1);
        check("t1_lat1_valid", 64'(out_valid), 64'd0);
        tick();
        check("t1_lat2_valid", 64'(out_valid), 64'd1);
        check("t1_lat2_src",   64'(out_src),   64'd1);
        check("t1_lat2_data",  64'(out_data),  64'(mk(1, 0)));

        // Backpressure: exactly OUT_DEPTH grants, then nothing until release.
        do_reset();
        out_ready = 1'b0;
        for (int s = 0; s < N; s++) load(s, 2);
        run(10);
        check("t3_head_a", 64'(out_data), 64'(mk(0, 0)));
        run(10);
        check("t3_grants", 64'(grant_q.size()), 64'd4);
        check("t3_req",    64'(fifo_r_req),     64'd0);
        check("t3_valid",  64'(out_valid),      64'd1);
        check("t3_head_b", 64'(out_data),       64'(mk(0, 0)));
        check("t3_src",    64'(out_src),        64'd0);
        check("t3_no_pop", 64'(out_q.size()),   64'd0);
        out_ready = 1'b1;
        run(20);
        check("t3_count", 64'(out_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) check_out("t3_word", i, i % 4, i / 4);
        check("t3_err", 64'(err_sticky), 64'd0);

        // Sparse: only FIFO 2 holds data, then 0 and 1 join the rotation.
        do_reset();
        load(2, 3);
        run(6);
        check("t4_grants_a", 64'(grant_q.size()), 64'd3);
        for (int i = 0; i < 3; i++) check_grant("t4_grant", i, 2);
        load(0, 1);
        load(1, 1);
        run(6);
        check("t4_grants_b", 64'(grant_q.size()), 64'd5);
        check_grant("t4_grant", 3, 0);
        check_grant("t4_grant", 4, 1);
        for (int i = 0; i < 3; i++) check_out("t4_word", i, 2, i);
        check_out("t4_word", 3, 0, 0);
        check_out("t4_word", 4, 1, 0);

        // Source disable with a request in flight, then re-enable.
        do_reset();
        load(0, 3);
        load(1, 3);
        tick();
        tick();
        src_enable[1] = 1'b0;
        run(8);
        check("t5_grants_a", 64'(grant_q.size()), 64'd4);
        check_grant("t5_grant", 0, 0);
        check_grant("t5_grant", 1, 1);
        check_grant("t5_grant", 2, 0);
        check_grant("t5_grant", 3, 0);
        check("t5_req_off", 64'(fifo_r_req), 64'd0);
        check_out("t5_word", 0, 0, 0);
        check_out("t5_word", 1, 1, 0);
        check_out("t5_word", 2, 0, 1);
        check_out("t5_word", 3, 0, 2);
        src_enable[1] = 1'b1;
        run(8);
        check_grant("t5_grant", 4, 1);
        check_grant("t5_grant", 5, 1);
        check_out("t5_word", 4, 1, 1);
        check_out("t5_word", 5, 1, 2);
        check("t5_err", 64'(err_sticky), 64'd0);

        // Stray r_valid with nothing in flight sets the sticky error.
        do_reset();
        check("t6_err_clear", 64'(err_sticky), 64'd0);
        fifo_r_valid = 4'b1000;
        #1;
        check("t6_err_not_comb", 64'(err_sticky), 64'd0);
        tick();
        check("t6_err_set", 64'(err_sticky), 64'd1);
        run(5);
        check("t6_err_hold", 64'(err_sticky), 64'd1);
        rst = 1'b1;
        #1;
        check("t6_err_rst", 64'(err_sticky), 64'd0);
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();

        // Missing r_valid for an in-flight request: word dropped, error set.
        drop = 1'b1;
        load(0, 1);
        tick();
        check("t6b_err_pre", 64'(err_sticky), 64'd0);
        tick();
        check("t6b_err_set", 64'(err_sticky), 64'd1);
        tick();
        check("t6b_dropped", 64'(out_valid), 64'd0);
        drop = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
